bn_seq_ctrl: RTL and testbench
==============================

BN_SEQ_CTRL -- requirements
Module: bn_seq_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): SIZE, 8, FP16 lanes per vector.
REQ-002 CHANNEL, 2, channel groups in the BN datapath; SIZE SHALL be divisible by CHANNEL.
REQ-003 LATENCY, 4, fixed cycle count from dp_x load to the matching dp_out; must be at least 1.
REQ-004 FIFO_DEPTH, 6, output buffer entries; must be at least LATENCY+1.
REQ-005 FRAME_LEN, 64, vectors per frame; must be at least 1.
REQ-006 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- reset, in, 1, asynchronous, active-high.
- start, in, 1, begins a frame; honoured only in IDLE.
- in_valid, in, 1, input vector valid.
- in_ready, out, 1, input vector accepted when in_valid and in_ready are both high.
- in_data, in, 16*SIZE, FP16 input vector.
- dp_x, out, 16*SIZE, registered vector driven to the BN datapath.
- dp_out, in, 16*SIZE, BN datapath result.
- out_valid, out, 1, output vector valid.
- out_ready, in, 1, downstream accept.
- out_data, out, 16*SIZE, FIFO head.
- out_last, out, 1, high with the FRAME_LEN-th output of a frame.
- busy, out, 1, high in RUN and DRAIN.
- done, out, 1, one-cycle pulse at frame completion.

Function
REQ-007 The FSM SHALL have four states, IDLE, RUN, DRAIN and DONE, with these transitions:
- IDLE to RUN on start; this clears in_cnt and out_cnt.
- RUN to DRAIN on the edge that accepts the FRAME_LEN-th input.
- DRAIN to DONE when out_cnt reaches FRAME_LEN.
- DONE to IDLE unconditionally after one cycle.
REQ-008 in_ready SHALL equal (state==RUN) AND (in_cnt<FRAME_LEN) AND (inflight+fifo_count<FIFO_DEPTH); this is a registered-count credit check with no same-cycle pop credit.
REQ-009 On an accept edge, dp_x SHALL load in_data, in_cnt SHALL increment, and valid-shift-register bit 0 SHALL be set; otherwise dp_x holds and bit 0 clears.
REQ-010 The valid shift register SHALL be LATENCY bits wide; inflight SHALL equal its popcount, kept as a counter that increments on accept and decrements on push, both possible in the same cycle.
REQ-011 When bit LATENCY-1 is high, dp_out SHALL be pushed into the FIFO on the next edge; an input accepted on edge E0 is pushed on edge E0+LATENCY.
REQ-012 out_valid SHALL be high while the FIFO is not empty; a pop occurs when out_valid and out_ready are both high, and out_cnt increments on each pop.
REQ-013 Order SHALL be preserved; out_data of the k-th pop corresponds to the k-th accepted input.
REQ-014 The credit check SHALL guarantee the FIFO never overflows; a push and a pop in the same cycle SHALL leave fifo_count unchanged.
REQ-015 out_last SHALL be high iff out_valid is high and out_cnt==FRAME_LEN-1.
REQ-016 start outside IDLE SHALL be ignored; start while in DONE SHALL NOT begin a new frame.
REQ-017 done SHALL be high exactly during the DONE cycle.
REQ-018 With out_ready held high, sustained throughput SHALL be 1 vector per cycle.
REQ-019 Counter widths SHALL be $clog2(FRAME_LEN+1) bits for the frame counters and $clog2(FIFO_DEPTH+1) bits for fifo_count and inflight.

Reset
REQ-020 While reset is high, the block SHALL asynchronously return to IDLE, and all counters, the shift register, FIFO pointers, dp_x, in_ready, out_valid, out_last, busy and done SHALL be 0.
REQ-021 Reset mid-frame SHALL discard in-flight and buffered vectors, and no output SHALL appear after reset deasserts until a new start.

Structure
REQ-022 Package bn_pkg SHALL hold DATA_WIDTH=16, the FSM state enum, and the FP16 constants ONE=16'h3C00 and QUARTER=16'h3400.
REQ-023 The output buffer SHALL be the sub-module bn_out_fifo, a synchronous FIFO parameterised by width and depth that exposes count, empty and full.

Verification
Use a bench model of the datapath that returns dp_x delayed by LATENCY cycles, with LATENCY=4, FIFO_DEPTH=6, FRAME_LEN=4 and SIZE=8.
REQ-024 Start, then 4 back-to-back inputs with lane0 = 0x3C00, 0x4000, 0x4200, 0x4400 and out_ready=1: the first out_valid appears 4 cycles after the first accept, the outputs are in order, out_last is on the 4th, and done pulses once.
REQ-025 out_ready=0 throughout with FRAME_LEN=8: in_ready drops after 6 accepts, and the FIFO holds 6 entries with no overflow; raising out_ready drains all 8 in order.
REQ-026 in_valid with no start: in_ready stays 0, out_valid stays 0 and busy stays 0.
REQ-027 Reset asserted 2 cycles after the 3rd accept: all outputs go 0 immediately, and no out_valid appears for 10 cycles after release.
REQ-028 start pulsed during RUN and during DONE: both are ignored, exactly 4 outputs are produced, and a following start in IDLE runs a second frame correctly.
REQ-029 Randomly toggled out_ready with a push and a pop in the same cycle: fifo_count stays unchanged on those cycles and data integrity holds over 4 frames.

Source files
------------

// File: rtl/bn_pkg.sv
// Shared definitions for the batch-norm sequencing controller: datapath
// word width, FSM state encoding and a few FP16 constants used around the
// BN datapath.
package bn_pkg;

   // Width of one FP16 lane.
   localparam int DATA_WIDTH = 16;

   // FP16 constants used by the BN datapath (1.0 and 0.25).
   localparam logic [15:0] ONE     = 16'h3C00;
   localparam logic [15:0] QUARTER = 16'h3400;

   // Controller states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } bn_state_e;

   // Advance a circular pointer, wrapping after last_idx.
   function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned last_idx);
      if (ptr >= last_idx) begin
         return 0;
      end else begin
         return ptr + 1;
      end
   endfunction

endpackage

// File: rtl/bn_out_fifo.sv
// Synchronous output buffer for BN results. Circular storage with separate
// read/write pointers and an occupancy counter; push and pop in the same
// cycle leave the occupancy unchanged. The head entry is always visible on
// pop_data.
import bn_pkg::*;

module bn_out_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 6
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             pop_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign do_push_s = push && (count_r != CW'(DEPTH));
   assign do_pop_s  = pop && (count_r != CW'(0));

   assign pop_data = mem_r[rd_ptr_r];
   assign count    = count_r;
   assign empty    = (count_r == CW'(0));
   assign full     = (count_r == CW'(DEPTH));

   // Storage write; contents need no reset because occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= PW'(0);
         rd_ptr_r <= PW'(0);
         count_r  <= CW'(0);
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= PW'(wrap_inc(32'(wr_ptr_r), 32'(DEPTH - 1)));
         end
         if (do_pop_s) begin
            rd_ptr_r <= PW'(wrap_inc(32'(rd_ptr_r), 32'(DEPTH - 1)));
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/bn_seq_ctrl.sv
// Batch-norm sequencing controller. Accepts FRAME_LEN input vectors per
// frame, drives them to a fixed-latency BN datapath through dp_x, tracks
// in-flight vectors with a valid shift register, and captures the datapath
// results into an output FIFO. Input acceptance is throttled by a credit
// check (in-flight plus buffered must stay below the FIFO depth), so the
// FIFO can never overflow even with downstream stalled.
import bn_pkg::*;

module bn_seq_ctrl #(
   parameter int SIZE       = 8,
   parameter int CHANNEL    = 2,
   parameter int LATENCY    = 4,
   parameter int FIFO_DEPTH = 6,
   parameter int FRAME_LEN  = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_WIDTH*SIZE-1:0] in_data,
   output logic [DATA_WIDTH*SIZE-1:0] dp_x,
   input  logic [DATA_WIDTH*SIZE-1:0] dp_out,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_WIDTH*SIZE-1:0] out_data,
   output logic                       out_last,
   output logic                       busy,
   output logic                       done
);

   localparam int VW  = DATA_WIDTH * SIZE;
   localparam int FCW = $clog2(FRAME_LEN + 1);
   localparam int QCW = $clog2(FIFO_DEPTH + 1);

   // Legacy-compatible state constants, tied to the package encoding.
   localparam logic [1:0] S_IDLE  = ST_IDLE;
   localparam logic [1:0] S_RUN   = ST_RUN;
   localparam logic [1:0] S_DRAIN = ST_DRAIN;
   localparam logic [1:0] S_DONE  = ST_DONE;

   // Elaboration-time parameter sanity.
   if ((SIZE % CHANNEL) != 0) begin : g_bad_channel
      $error("bn_seq_ctrl: SIZE must be divisible by CHANNEL");
   end
   if (LATENCY < 1) begin : g_bad_latency
      $error("bn_seq_ctrl: LATENCY must be at least 1");
   end
   if (FIFO_DEPTH < LATENCY + 1) begin : g_bad_depth
      $error("bn_seq_ctrl: FIFO_DEPTH must be at least LATENCY+1");
   end
   if (FRAME_LEN < 1) begin : g_bad_frame
      $error("bn_seq_ctrl: FRAME_LEN must be at least 1");
   end

   logic [1:0]         state_r;
   logic [1:0]         state_nxt_s;
   logic [FCW-1:0]     in_cnt_r;
   logic [FCW-1:0]     out_cnt_r;
   logic [QCW-1:0]     inflight_r;
   logic [QCW-1:0]     fifo_count_s;
   logic [QCW:0]       credit_s;
   logic [LATENCY-1:0] vsr_r;
   logic [VW-1:0]      dp_x_r;
   logic               busy_r;
   logic               done_r;
   logic               accept_s;
   logic               push_s;
   logic               pop_s;
   logic               fifo_empty_s;
   logic               fifo_full_s;
   logic               frame_start_s;

   // Credit uses registered counts only; a pop this cycle does not free a slot
   // until the next cycle. The full term is redundant with the credit bound.
   assign credit_s      = {1'b0, inflight_r} + {1'b0, fifo_count_s};
   assign in_ready      = (state_r == S_RUN) && (in_cnt_r < FCW'(FRAME_LEN))
                          && (credit_s < (QCW+1)'(FIFO_DEPTH)) && !fifo_full_s;
   assign accept_s      = in_valid && in_ready;
   assign push_s        = vsr_r[LATENCY-1];
   assign out_valid     = !fifo_empty_s;
   assign pop_s         = out_valid && out_ready;
   assign out_last      = out_valid && (out_cnt_r == FCW'(FRAME_LEN - 1));
   assign frame_start_s = (state_r == S_IDLE) && start;
   assign dp_x          = dp_x_r;
   assign busy          = busy_r;
   assign done          = done_r;

   // Next-state decode for the frame sequencer.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_nxt_s = S_RUN;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_RUN: begin
            if (accept_s && (in_cnt_r == FCW'(FRAME_LEN - 1))) begin
               state_nxt_s = S_DRAIN;
            end else begin
               state_nxt_s = S_RUN;
            end
         end
         S_DRAIN: begin
            if (out_cnt_r == FCW'(FRAME_LEN)) begin
               state_nxt_s = S_DONE;
            end else begin
               state_nxt_s = S_DRAIN;
            end
         end
         S_DONE: begin
            state_nxt_s = S_IDLE;
         end
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // State register plus busy/done flags registered alongside it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= S_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= (state_nxt_s == S_RUN) || (state_nxt_s == S_DRAIN);
         done_r  <= (state_nxt_s == S_DONE);
      end
   end

   // Frame input/output counters, cleared when a frame starts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_cnt_r  <= FCW'(0);
         out_cnt_r <= FCW'(0);
      end else if (frame_start_s) begin
         in_cnt_r  <= FCW'(0);
         out_cnt_r <= FCW'(0);
      end else begin
         if (accept_s) begin
            in_cnt_r <= in_cnt_r + FCW'(1);
         end
         if (pop_s) begin
            out_cnt_r <= out_cnt_r + FCW'(1);
         end
      end
   end

   // Valid shift register marks which datapath stages hold a live vector.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vsr_r <= LATENCY'(0);
      end else begin
         vsr_r <= (vsr_r << 1) | LATENCY'(accept_s);
      end
   end

   // In-flight counter mirrors the popcount of the valid shift register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight_r <= QCW'(0);
      end else begin
         case ({accept_s, push_s})
            2'b10:   inflight_r <= inflight_r + QCW'(1);
            2'b01:   inflight_r <= inflight_r - QCW'(1);
            default: inflight_r <= inflight_r;
         endcase
      end
   end

   // Datapath operand register: loads on accept, otherwise holds.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dp_x_r <= VW'(0);
      end else if (accept_s) begin
         dp_x_r <= in_data;
      end else begin
         dp_x_r <= dp_x_r;
      end
   end

   bn_out_fifo #(
      .WIDTH (VW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_s),
      .push_data (dp_out),
      .pop       (pop_s),
      .pop_data  (out_data),
      .count     (fifo_count_s),
      .empty     (fifo_empty_s),
      .full      (fifo_full_s)
   );

endmodule

// File: tb/tb_bn_seq_ctrl.sv
// Self-checking bench for bn_seq_ctrl. Two instances: FRAME_LEN=4 for most
// sequences and FRAME_LEN=8 for the stalled-downstream case. Each has a
// datapath model that, together with the dp_x register, gives LATENCY cycles
// from accept to the FIFO push.
module tb_bn_seq_ctrl;
   import bn_pkg::*;

   localparam int SIZE  = 8;
   localparam int LAT   = 4;
   localparam int DEPTH = 6;
   localparam int VW    = 16 * SIZE;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic          start, in_valid, in_ready, out_valid, out_ready, out_last, busy, done;
   logic [VW-1:0] in_data, dp_x, dp_out, out_data;
   logic          b_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy, b_done;
   logic [VW-1:0] b_in_data, b_dp_x, b_dp_out, b_out_data;

   bn_seq_ctrl #(.SIZE(SIZE), .CHANNEL(2), .LATENCY(LAT), .FIFO_DEPTH(DEPTH), .FRAME_LEN(4)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .dp_x(dp_x), .dp_out(dp_out), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy), .done(done));

   bn_seq_ctrl #(.SIZE(SIZE), .CHANNEL(2), .LATENCY(LAT), .FIFO_DEPTH(DEPTH), .FRAME_LEN(8)) dut8 (
      .clk(clk), .reset(reset), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .dp_x(b_dp_x), .dp_out(b_dp_out), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last), .busy(b_busy), .done(b_done));

   // Datapath models: LAT-1 further register stages behind dp_x.
   logic [VW-1:0] pipe_a [LAT-1];
   logic [VW-1:0] pipe_b [LAT-1];
   always @(posedge clk) begin
      pipe_a[0] <= dp_x;
      pipe_b[0] <= b_dp_x;
      for (int i = 1; i < LAT - 1; i++) begin
         pipe_a[i] <= pipe_a[i-1];
         pipe_b[i] <= pipe_b[i-1];
      end
   end
   assign dp_out   = pipe_a[LAT-2];
   assign b_dp_out = pipe_b[LAT-2];

   int errors = 0;
   int checks = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic chkv(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Vector whose lane k carries lane0 + k.
   function automatic logic [VW-1:0] mkvec(input logic [15:0] l0);
      logic [VW-1:0] v;
      for (int k = 0; k < SIZE; k++) begin
         v[16*k +: 16] = l0 + 16'(k);
      end
      return v;
   endfunction

   typedef struct {
      logic        st;
      logic        iv;
      logic [15:0] din;
      logic        ordy;
      logic        ir;
      logic        ov;
      logic        ol;
      logic [15:0] dout;
      logic        bsy;
      logic        dn;
   } vec_t;

   vec_t tbl [13];

   // One full frame on dut (FRAME_LEN=4) with a scoreboard and a per-cycle
   // FIFO occupancy check (count' = count + push - pop).
   task automatic run_frame(input logic [15:0] base, input bit rnd, input bit pulse_run,
                            input bit pulse_done, input string tag);
      int sent, rcv, dones, pre_cnt;
      bit pend, pre_push, pre_pop, fin;
      sent = 0; rcv = 0; dones = 0; pre_cnt = 0; pend = 0; pre_push = 0; pre_pop = 0; fin = 0;
      @(negedge clk); start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
         if (pend) begin
            chki({tag, "_fifo_count"}, int'(dut.u_fifo.count),
                 pre_cnt + int'(pre_push) - int'(pre_pop));
         end
         in_valid  = (sent < 4);
         in_data   = mkvec(base + 16'(sent));
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         start     = pulse_run && (sent == 2);
         #1;
         if (done) begin
            dones++;
            fin = 1'b1;
            if (pulse_done) start = 1'b1;
         end
         if (out_valid && out_ready) begin
            chkv({tag, "_out_data"}, out_data, mkvec(base + 16'(rcv)));
            chk1({tag, "_out_last"}, out_last, rcv == 3);
            rcv++;
         end
         pre_cnt  = int'(dut.u_fifo.count);
         pre_push = dut.vsr_r[LAT-1];
         pre_pop  = out_valid && out_ready;
         pend     = 1'b1;
         if (in_valid && in_ready) sent++;
         @(negedge clk);
      end
      start = 1'b0; in_valid = 1'b0;
      chk1({tag, "_done_seen"}, fin, 1'b1);
      chki({tag, "_outputs"}, rcv, 4);
      chki({tag, "_inputs"}, sent, 4);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk1({tag, "_post_done"}, done, 1'b0);
         chk1({tag, "_post_busy"}, busy, 1'b0);
         chk1({tag, "_post_ready"}, in_ready, 1'b0);
         @(negedge clk);
      end
   endtask

   // Global time limit so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int bsent, brcv, bad;
      logic [VW-1:0] vzero;
      vzero = '0;

      //            st    iv    din       ordy  ir    ov    ol    dout      bsy   dn
      tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 16'h3C00, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 16'h4000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 16'h4200, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 16'h4400, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h3C00, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h4000, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h4200, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h4400, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
      tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};

      reset = 1'b1;
      start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      b_start = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk1("rst_in_ready", in_ready, 1'b0);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk1("rst_out_last", out_last, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chkv("rst_dp_x", dp_x, vzero);
      @(negedge clk); reset = 1'b0;

      // in_valid without start: nothing moves.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); in_valid = 1'b1; in_data = mkvec(16'h1234); out_ready = 1'b1;
         #1;
         chk1("nostart_in_ready", in_ready, 1'b0);
         chk1("nostart_out_valid", out_valid, 1'b0);
         chk1("nostart_busy", busy, 1'b0);
      end
      in_valid = 1'b0;

      // Back-to-back frame, cycle-exact table.
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         start = tbl[i].st; in_valid = tbl[i].iv; in_data = mkvec(tbl[i].din); out_ready = tbl[i].ordy;
         #1;
         chk1($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].ir);
         chk1($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ov);
         chk1($sformatf("tbl%0d_out_last", i), out_last, tbl[i].ol);
         chk1($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
         chk1($sformatf("tbl%0d_done", i), done, tbl[i].dn);
         if (tbl[i].ov) chkv($sformatf("tbl%0d_out_data", i), out_data, mkvec(tbl[i].dout));
      end
      start = 1'b0; in_valid = 1'b0;

      // FRAME_LEN=8 with downstream stalled: credit stops at 6 accepts.
      bsent = 0; brcv = 0;
      @(negedge clk); b_start = 1'b1; b_out_ready = 1'b0;
      @(negedge clk); b_start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         b_in_valid = (bsent < 8); b_in_data = mkvec(16'h1000 + 16'(bsent));
         #1;
         if (b_in_valid && b_in_ready) bsent++;
         @(negedge clk);
      end
      #1;
      chki("stall_accepts", bsent, 6);
      chk1("stall_in_ready", b_in_ready, 1'b0);
      chki("stall_fifo_count", int'(dut8.u_fifo.count), 6);
      chk1("stall_out_valid", b_out_valid, 1'b1);
      for (int i = 0; i < 60 && brcv < 8; i++) begin
         @(negedge clk);
         b_out_ready = 1'b1; b_in_valid = (bsent < 8); b_in_data = mkvec(16'h1000 + 16'(bsent));
         #1;
         if (b_out_valid) begin
            chkv("drain_out_data", b_out_data, mkvec(16'h1000 + 16'(brcv)));
            chk1("drain_out_last", b_out_last, brcv == 7);
            brcv++;
         end
         if (b_in_valid && b_in_ready) bsent++;
      end
      b_in_valid = 1'b0;
      chki("drain_outputs", brcv, 8);
      chki("drain_inputs", bsent, 8);

      // Reset two cycles after the third accept of a frame.
      @(negedge clk); start = 1'b1; out_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_data = mkvec(16'h5000 + 16'(k));
         #1;
         chk1("midrst_accept", in_ready, 1'b1);
         @(negedge clk);
      end
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk1("midrst_pre_valid", out_valid, 1'b1);
      reset = 1'b1;
      #1;
      chk1("midrst_in_ready", in_ready, 1'b0);
      chk1("midrst_out_valid", out_valid, 1'b0);
      chk1("midrst_out_last", out_last, 1'b0);
      chk1("midrst_busy", busy, 1'b0);
      chk1("midrst_done", done, 1'b0);
      chkv("midrst_dp_x", dp_x, vzero);
      chki("midrst_fifo_count", int'(dut.u_fifo.count), 0);
      @(negedge clk); reset = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         if (out_valid || busy) bad++;
      end
      in_valid = 1'b0;
      chki("postrst_quiet", bad, 0);

      // start in RUN and in DONE is ignored; then a clean second frame.
      run_frame(16'h3000, 1'b0, 1'b1, 1'b1, "ign");
      run_frame(16'h3100, 1'b0, 1'b0, 1'b0, "second");

      // Random downstream back-pressure over four frames.
      for (int f = 0; f < 4; f++) begin
         run_frame(16'h2000 + 16'(f * 256), 1'b1, 1'b0, 1'b0, $sformatf("rnd%0d", f));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
